key_step_conditioner: RTL and testbench

- Upstream input stage for the lab sequence-detector FSM.
- Takes a raw, bouncy, active-low push-button and a raw slide switch, both asynchronous to the system clock, and synchronizes them.
- Debounces the button into exactly one single-cycle step pulse per physical press.
- Captures the switch value at the moment the press is accepted, so the downstream FSM can use step as its clock enable and w_out as its w input on the 50 MHz board clock, instead of clocking directly off KEY[0].

---
 rtl/key_step_conditioner_if.sv | 32 +++
 rtl/key_step_conditioner.sv | 127 ++++++++++++
 tb/tb_key_step_conditioner.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/key_step_conditioner_if.sv
// Button/switch bundle between the board pins and the sequence-detector FSM.
// master: the side driving the raw pins and observing the conditioned outputs.
// slave:  the conditioner itself.
interface key_step_if;
    logic       key_n;
    logic       w_in;
    logic       step;
    logic       w_out;
    logic       held;
    logic [7:0] press_count;
    logic [1:0] dbg_state;

    modport master (
        output key_n,
        output w_in,
        input  step,
        input  w_out,
        input  held,
        input  press_count,
        input  dbg_state
    );

    modport slave (
        input  key_n,
        input  w_in,
        output step,
        output w_out,
        output held,
        output press_count,
        output dbg_state
    );
endinterface

// File: rtl/key_step_conditioner.sv
// Synchronizes a bouncy active-low push-button and a slide switch, turns each
// accepted press into a single-cycle step pulse, and captures the switch value
// on that pulse so the downstream FSM runs on clk_sys with step as its enable.
//
// state        | meaning
// -------------+---------------------------------------------------------
// IDLE         | button released and stable
// PRESS_WAIT   | button seen pressed, counting stable cycles before accepting
// HELD         | press accepted, waiting for the button to be let go
// RELEASE_WAIT | button seen released, counting stable cycles before idling
module key_step_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       clk_sys_i,
    input  logic       rst_i,
    key_step_if.slave  ksc_bus
);

    localparam logic [1:0] IDLE         = 2'b00;
    localparam logic [1:0] PRESS_WAIT   = 2'b01;
    localparam logic [1:0] HELD         = 2'b10;
    localparam logic [1:0] RELEASE_WAIT = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             key_meta_q;
    logic             key_s_q;
    logic             w_meta_q;
    logic             w_s_q;
    logic             pressed;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_q, step_d;
    logic             w_out_q, w_out_d;
    logic [7:0]       press_count_q, press_count_d;

    // Two-flop synchronizers; key idles released (1), switch idles low.
    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            key_meta_q <= 1'b1;
            key_s_q    <= 1'b1;
            w_meta_q   <= 1'b0;
            w_s_q      <= 1'b0;
        end else begin
            key_meta_q <= ksc_bus.key_n;
            key_s_q    <= key_meta_q;
            w_meta_q   <= ksc_bus.w_in;
            w_s_q      <= w_meta_q;
        end
    end

    assign pressed = ~key_s_q;

    // Debounce FSM next-state; the counter restarts from zero on every state change.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        step_d        = 1'b0;
        w_out_d       = w_out_q;
        press_count_d = press_count_q;
        case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = HELD;
                    cnt_d         = '0;
                    step_d        = 1'b1;
                    w_out_d       = w_s_q;
                    press_count_d = press_count_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!pressed) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (pressed) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            step_q        <= 1'b0;
            w_out_q       <= 1'b0;
            press_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            step_q        <= step_d;
            w_out_q       <= w_out_d;
            press_count_q <= press_count_d;
        end
    end

    assign ksc_bus.step        = step_q;
    assign ksc_bus.w_out       = w_out_q;
    assign ksc_bus.held        = state_q[1];
    assign ksc_bus.press_count = press_count_q;
    assign ksc_bus.dbg_state   = state_q;

endmodule

// File: tb/tb_key_step_conditioner.sv
// Bench for key_step_conditioner with a short debounce window.
module tb_key_step_conditioner;
    localparam int DC = 4;
    localparam int CW = 3;
    // Press driven at a negedge -> step visible at the negedge DC+3 cycles later
    // (2 synchronizer edges, 1 IDLE->PRESS_WAIT edge, DC counting edges).
    localparam int STEP_LAT = DC + 3;

    typedef struct {
        int         cyc;
        logic       w;
        logic [7:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    key_step_if bus();

    key_step_conditioner #(.DEBOUNCE_CYCLES(DC), .CNT_W(CW)) dut (
        .clk_sys_i (clk),
        .rst_i     (rst),
        .ksc_bus   (bus)
    );

    exp_t       sb_q[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_count = 8'd0;
    logic       step_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_press(input logic w);
        exp_count = exp_count + 8'd1;
        sb_q.push_back('{cyc: cyc + STEP_LAT, w: w, cnt: exp_count});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.key_n = 1'b1;
        sb_q.delete();
        exp_count = 8'd0;
        step_prev = 1'b0;
        wait_n(2);
        rst = 1'b0;
    endtask

    task automatic press_release(input logic w, input int hold, input int rel);
        bus.w_in  = w;
        bus.key_n = 1'b0;
        push_press(w);
        wait_n(hold);
        bus.key_n = 1'b1;
        wait_n(rel);
    endtask

    // Edge counter used to time-stamp steps.
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every step must match the oldest pending press.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.step) begin
                if (sb_q.size() == 0) begin
                    chk("unexp_step", bus.step, 1'b0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("step_cyc", cyc, e.cyc);
                    chk("w_out", bus.w_out, e.w);
                    chk("press_count", bus.press_count, e.cnt);
                    chk("held_on_step", bus.held, 1'b1);
                    chk("state_on_step", bus.dbg_state, 2'b10);
                end
                if (step_prev) chk("step_twice", bus.step, 1'b0);
            end
            step_prev = bus.step;
        end
    end

    initial begin
        logic [1:0] seen[$];
        logic [1:0] exp_seq[4];
        logic [1:0] prev;

        bus.key_n = 1'b1;
        bus.w_in  = 1'b0;
        wait_n(3);
        chk("rst_state", bus.dbg_state, 2'b00);
        chk("rst_step", bus.step, 1'b0);
        chk("rst_w_out", bus.w_out, 1'b0);
        chk("rst_count", bus.press_count, 8'd0);
        chk("rst_held", bus.held, 1'b0);
        rst = 1'b0;

        // 1: reset mid-PRESS_WAIT, then a fresh full debounce, then reset during step
        bus.key_n = 1'b0;
        wait_n(3);
        chk("pre_rst_state", bus.dbg_state, 2'b01);
        #2 rst = 1'b1;
        #1;
        chk("midrst_state", bus.dbg_state, 2'b00);
        chk("midrst_step", bus.step, 1'b0);
        chk("midrst_w_out", bus.w_out, 1'b0);
        chk("midrst_count", bus.press_count, 8'd0);
        bus.w_in = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push_press(1'b1);
        wait_n(STEP_LAT);
        chk("step_pre_rst", bus.step, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("steprst_step", bus.step, 1'b0);
        chk("steprst_count", bus.press_count, 8'd0);
        chk("steprst_w_out", bus.w_out, 1'b0);

        // 2: clean press and release, no auto-repeat while held
        do_reset();
        press_release(1'b1, 20, 10);
        chk("clean_held", bus.held, 1'b0);
        chk("clean_state", bus.dbg_state, 2'b00);
        chk("clean_count", bus.press_count, 8'd1);

        // 3: bounce on press
        do_reset();
        bus.w_in  = 1'b0;
        bus.key_n = 1'b0; wait_n(3);
        bus.key_n = 1'b1; wait_n(1);
        bus.key_n = 1'b0; wait_n(3);
        bus.key_n = 1'b1; wait_n(1);
        bus.key_n = 1'b0;
        push_press(1'b0);
        wait_n(12);
        bus.key_n = 1'b1;
        wait_n(10);
        chk("bounce_count", bus.press_count, 8'd1);
        chk("bounce_state", bus.dbg_state, 2'b00);

        // 4: bounce on release
        do_reset();
        bus.key_n = 1'b0;
        push_press(1'b0);
        wait_n(STEP_LAT + 2);
        chk("rel_start", bus.dbg_state, 2'b10);
        prev = 2'b10;
        for (int i = 0; i < 16; i++) begin
            if (i == 0) bus.key_n = 1'b1;
            if (i == 2) bus.key_n = 1'b0;
            if (i == 3) bus.key_n = 1'b1;
            @(negedge clk);
            if (bus.dbg_state != prev) begin
                seen.push_back(bus.dbg_state);
                prev = bus.dbg_state;
            end
        end
        exp_seq[0] = 2'b11;
        exp_seq[1] = 2'b10;
        exp_seq[2] = 2'b11;
        exp_seq[3] = 2'b00;
        chk("rel_seq_len", seen.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < seen.size()) chk($sformatf("rel_seq%0d", i), seen[i], exp_seq[i]);
        end

        // 5: switch capture
        do_reset();
        bus.w_in  = 1'b0;
        bus.key_n = 1'b0;
        push_press(1'b0);
        wait_n(STEP_LAT + 2);
        bus.w_in = 1'b1;
        wait_n(6);
        chk("w_hold_held", bus.w_out, 1'b0);
        bus.key_n = 1'b1;
        wait_n(10);
        chk("w_hold_idle", bus.w_out, 1'b0);
        press_release(1'b1, 10, 10);
        // w_in falls too late to reach w_s before the accepting edge
        bus.key_n = 1'b0;
        push_press(1'b1);
        wait_n(STEP_LAT - 2);
        bus.w_in = 1'b0;
        wait_n(5);
        chk("w_late_change", bus.w_out, 1'b1);
        bus.key_n = 1'b1;
        wait_n(10);

        // 6: press counter wrap
        do_reset();
        for (int i = 0; i < 256; i++) press_release(i[0], 8, 10);
        chk("wrap_256", bus.press_count, 8'd0);
        press_release(1'b1, 8, 10);
        chk("wrap_257", bus.press_count, 8'd1);

        chk("sb_drain", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
